sram_test_controller: RTL
=========================

Name: sram_test_controller

Overview:
- Sequences a full write-then-verify sweep of the external async SRAM for the SRAM test example.
- Owns the address counter, the SRAM control strobes (we_n/oe_n), data-bus direction and the expected-data pattern.
- Compares read-back data and reports pass/fail plus first-failure details to the top level (LEDs/UART).

Parameters:
- ADDR_BITS, 20, SRAM address width; sweep covers 0 .. 2^ADDR_BITS-1.
- DATA_BITS, 16, SRAM data width.
- READ_WAIT, 2, cycles oe_n is held low before sampling data_in; legal range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  level or pulse; sampled in IDLE/DONE/FAIL to begin a sweep.
- addr  output  ADDR_BITS  SRAM address.
- data_out  output  DATA_BITS  write data to the bus pad.
- data_oe  output  1  1 = FPGA drives the data bus.
- data_in  input  DATA_BITS  read data from the bus pad.
- we_n  output  1  SRAM write enable, active-low.
- oe_n  output  1  SRAM output enable, active-low.
- busy  output  1  sweep in progress.
- done  output  1  last sweep completed with no mismatch; sticky until next start.
- fail  output  1  mismatch detected; sticky until next start.
- error_addr  output  ADDR_BITS  address of first mismatch.
- error_expected  output  DATA_BITS  expected data at error_addr.
- error_actual  output  DATA_BITS  data_in sampled at error_addr.

Behaviour:
- Reset values: state IDLE; addr=0; data_out=0; data_oe=0; we_n=1; oe_n=1; busy=0; done=0; fail=0; error_* = 0; seed=0.
- Pattern: expected(a) = a[DATA_BITS-1:0] ^ {DATA_BITS{seed}}. Zero-extend a when ADDR_BITS < DATA_BITS.
- Last address: addr == all-ones. The counter never wraps inside a sweep.
- IDLE/DONE/FAIL, start=1:
  - clear done, fail and error_*.
  - addr <= 0; busy <= 1; go to W_SETUP.
- W_SETUP (1 cycle): data_oe=1, data_out=expected(addr), we_n=1 -> W_PULSE.
- W_PULSE (1 cycle): we_n=0; addr and data held -> W_HOLD.
- W_HOLD (1 cycle): we_n=1, data_oe still 1.
  - Not last address: addr+1 -> W_SETUP.
  - Last address: addr <= 0 -> R_SETUP.
- Write cycle is 3 clk per address. addr and data never change while we_n=0.
- R_SETUP (1 cycle): data_oe=0, oe_n=1. Provides bus turnaround -> R_WAIT with wait counter=0.
- R_WAIT: oe_n=0; counter increments each cycle; after READ_WAIT cycles -> R_CHECK.
- R_CHECK (1 cycle): oe_n=0; compare data_in with expected(addr).
  - Mismatch: latch error_addr/expected/actual; fail <= 1; busy <= 0; oe_n <= 1 -> FAIL.
  - Match, not last address: addr+1, oe_n <= 1 -> R_SETUP.
  - Match, last address: busy <= 0, done <= 1 -> DONE.
- data_oe and oe_n are never both active. Every write-to-read and read-to-read transition has at least one cycle with data_oe=0 and oe_n=1.
- start while busy is ignored.
- Asserting reset mid-sweep forces all reset values immediately (strobes deassert asynchronously).
- done/fail/error_* hold their values in DONE/FAIL until the next start.

Optional Feature:
- Macro SRAM_TEST_LOOP_EN.
- Defined:
  - On a successful last R_CHECK, seed toggles, addr <= 0 and the block goes to W_SETUP. busy stays 1.
  - Adds output pass_count[15:0]: reset 0, cleared on start, increments per clean sweep, saturates at 16'hFFFF.
  - The controller stops only on mismatch (FAIL) or reset; done is never set.
- Not defined:
  - Single sweep with seed=0, ending in DONE.
  - No pass_count port.

Decomposition:
- Shared include sram_test_defs.vh: state encoding localparams (IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, R_CHECK, DONE, FAIL) and the default widths.
- Sub-module sram_test_pattern: combinational expected-data function of (addr, seed). Shared with any future standalone checker.

Test Plan:
- ADDR_BITS=4, DATA_BITS=8, READ_WAIT=2, behavioural SRAM model.
  - reset released, start pulse -> 16 write pulses at addr 0..15 with data 0x00..0x0F, then 16 reads; done=1, fail=0, busy=0.
  - Total sweep is 48 + 16*(1+2+1) = 112 cycles from start to DONE.
- Model corrupts addr 0x9 (bit 3 stuck-at-0 on read):
  - fail=1, error_addr=0x9, error_expected=0x09, error_actual=0x01.
  - No read of addr 0xA occurs.
- Protocol monitor across a full sweep:
  - never data_oe=1 with oe_n=0.
  - addr/data_out stable throughout every we_n=0 cycle.
- reset driven low during R_WAIT at addr 0x5:
  - same cycle (async): we_n=1, oe_n=1, data_oe=0, busy=0, addr=0.
  - after release plus start: a clean full sweep.
- start held high during a sweep -> no restart. After DONE, held start launches a new sweep that clears done in the first cycle.
- With SRAM_TEST_LOOP_EN: three clean sweeps -> pass_count=3.
  - Second sweep writes inverted data (addr 0x3 -> 0xFC).
  - Injected error in the third sweep -> fail=1, pass_count=2.

Source files
------------

// File: rtl/sram_test_controller_pkg.sv
// Shared definitions for the SRAM write-then-verify sweep controller.
// Contents: default widths, the read-wait counter width and the controller
// state type. Imported by sram_test_pattern and sram_test_controller.
package sram_test_controller_pkg;

   localparam int unsigned DEF_ADDR_BITS = 20;
   localparam int unsigned DEF_DATA_BITS = 16;
   localparam int unsigned DEF_READ_WAIT = 2;

   // READ_WAIT is limited to 1..15, so four bits hold the wait count.
   localparam int unsigned WAIT_BITS = 4;

   typedef enum logic [3:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_SETUP,
      R_WAIT,
      R_CHECK,
      DONE,
      FAIL
   } state_t;

endpackage

// File: rtl/sram_test_pattern.sv
// Expected-data generator for the SRAM sweep:
//   expected = addr (truncated or zero-extended to DATA_BITS) XOR {DATA_BITS{seed}}.
// Purely combinational so a standalone checker can reuse it.
// Ports:
//   addr     in   ADDR_BITS  address being written or checked
//   seed     in   1          pattern polarity (1 = inverted data)
//   expected out  DATA_BITS  data that must be stored at addr
module sram_test_pattern
   import sram_test_controller_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
   parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
   input  logic [ADDR_BITS-1:0] addr,
   input  logic                 seed,
   output logic [DATA_BITS-1:0] expected
);

   logic [DATA_BITS-1:0] addr_ext;

   generate
      if (ADDR_BITS > DATA_BITS) begin : g_trunc
         // Upper address bits do not take part in the pattern.
         logic unused_hi;
         assign unused_hi = ^addr[ADDR_BITS-1:DATA_BITS];
         assign addr_ext  = addr[DATA_BITS-1:0];
      end else if (ADDR_BITS == DATA_BITS) begin : g_same
         assign addr_ext = addr;
      end else begin : g_zext
         assign addr_ext = {{(DATA_BITS-ADDR_BITS){1'b0}}, addr};
      end
   endgenerate

   assign expected = addr_ext ^ {DATA_BITS{seed}};

endmodule

// File: rtl/sram_test_controller.sv
// Write-then-verify sweep controller for an external asynchronous SRAM.
// Writes expected(a) to every address 0..2^ADDR_BITS-1 (3 clk per address),
// then reads each address back (1 turnaround + READ_WAIT + 1 check clk) and
// stops on the first mismatch, latching its address/expected/actual data.
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous reset, active low
//   start          in   begins a sweep when idle, done or failed
//   addr           out  SRAM address
//   data_out       out  write data to the bus pad
//   data_oe        out  1 = FPGA drives the data bus
//   data_in        in   read data from the bus pad
//   we_n / oe_n    out  SRAM write / output enable, active low
//   busy           out  sweep in progress
//   done / fail    out  sticky sweep result, cleared by the next start
//   error_addr/_expected/_actual  out  first mismatch details
// Build option SRAM_TEST_LOOP_EN: sweeps repeat forever with alternating data
// polarity, counting clean sweeps on pass_count; only a mismatch stops it.
module sram_test_controller
   import sram_test_controller_pkg::*;
#(
   parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
   parameter int unsigned DATA_BITS = DEF_DATA_BITS,
   parameter int unsigned READ_WAIT = DEF_READ_WAIT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [ADDR_BITS-1:0] addr,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_oe,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 we_n,
   output logic                 oe_n,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [ADDR_BITS-1:0] error_addr,
   output logic [DATA_BITS-1:0] error_expected,
   output logic [DATA_BITS-1:0] error_actual
`ifdef SRAM_TEST_LOOP_EN
   ,
   output logic [15:0]          pass_count
`endif
);

   state_t               state, state_nx;
   logic [ADDR_BITS-1:0] addr_nx;
   logic                 busy_nx, done_nx, fail_nx;
   logic [ADDR_BITS-1:0] error_addr_nx;
   logic [DATA_BITS-1:0] error_expected_nx, error_actual_nx;
   logic                 seed, seed_nx;
   logic [WAIT_BITS-1:0] wait_cnt, wait_cnt_nx;
   logic [DATA_BITS-1:0] expected;
   logic                 last_addr;
`ifdef SRAM_TEST_LOOP_EN
   logic [15:0]          pass_count_nx;
`endif

   sram_test_pattern #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS)
   ) u_pattern (
      .addr     (addr),
      .seed     (seed),
      .expected (expected)
   );

   assign last_addr = &addr;

   // Strobes are decoded from the state register, so an asynchronous reset
   // returns them to their inactive levels without waiting for a clock.
   always_comb begin
      state_nx          = state;
      addr_nx           = addr;
      busy_nx           = busy;
      done_nx           = done;
      fail_nx           = fail;
      error_addr_nx     = error_addr;
      error_expected_nx = error_expected;
      error_actual_nx   = error_actual;
      seed_nx           = seed;
      wait_cnt_nx       = wait_cnt;
`ifdef SRAM_TEST_LOOP_EN
      pass_count_nx     = pass_count;
`endif
      data_out          = '0;
      data_oe           = 1'b0;
      we_n              = 1'b1;
      oe_n              = 1'b1;

      case (state)
         IDLE, DONE, FAIL: begin
            if (start) begin
               done_nx           = 1'b0;
               fail_nx           = 1'b0;
               error_addr_nx     = '0;
               error_expected_nx = '0;
               error_actual_nx   = '0;
               addr_nx           = '0;
               busy_nx           = 1'b1;
               // Every new sweep begins with non-inverted data.
               seed_nx           = 1'b0;
`ifdef SRAM_TEST_LOOP_EN
               pass_count_nx     = '0;
`endif
               state_nx          = W_SETUP;
            end
         end
         W_SETUP: begin
            data_oe  = 1'b1;
            data_out = expected;
            state_nx = W_PULSE;
         end
         W_PULSE: begin
            data_oe  = 1'b1;
            data_out = expected;
            we_n     = 1'b0;
            state_nx = W_HOLD;
         end
         W_HOLD: begin
            data_oe  = 1'b1;
            data_out = expected;
            if (last_addr) begin
               addr_nx  = '0;
               state_nx = R_SETUP;
            end else begin
               addr_nx  = addr + ADDR_BITS'(1);
               state_nx = W_SETUP;
            end
         end
         R_SETUP: begin
            wait_cnt_nx = '0;
            state_nx    = R_WAIT;
         end
         R_WAIT: begin
            oe_n = 1'b0;
            if (wait_cnt == WAIT_BITS'(READ_WAIT - 1)) begin
               state_nx = R_CHECK;
            end else begin
               wait_cnt_nx = wait_cnt + WAIT_BITS'(1);
            end
         end
         R_CHECK: begin
            oe_n = 1'b0;
            if (data_in != expected) begin
               error_addr_nx     = addr;
               error_expected_nx = expected;
               error_actual_nx   = data_in;
               fail_nx           = 1'b1;
               busy_nx           = 1'b0;
               state_nx          = FAIL;
            end else if (!last_addr) begin
               addr_nx  = addr + ADDR_BITS'(1);
               state_nx = R_SETUP;
            end else begin
`ifdef SRAM_TEST_LOOP_EN
               if (pass_count != 16'hFFFF) begin
                  pass_count_nx = pass_count + 16'd1;
               end
               seed_nx  = ~seed;
               addr_nx  = '0;
               state_nx = W_SETUP;
`else
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               state_nx = DONE;
`endif
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         addr           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         fail           <= 1'b0;
         error_addr     <= '0;
         error_expected <= '0;
         error_actual   <= '0;
         seed           <= 1'b0;
         wait_cnt       <= '0;
`ifdef SRAM_TEST_LOOP_EN
         pass_count     <= '0;
`endif
      end else begin
         state          <= state_nx;
         addr           <= addr_nx;
         busy           <= busy_nx;
         done           <= done_nx;
         fail           <= fail_nx;
         error_addr     <= error_addr_nx;
         error_expected <= error_expected_nx;
         error_actual   <= error_actual_nx;
         seed           <= seed_nx;
         wait_cnt       <= wait_cnt_nx;
`ifdef SRAM_TEST_LOOP_EN
         pass_count     <= pass_count_nx;
`endif
      end
   end

endmodule
